// File: rtl/d_cache_responder_if.sv
// d_cache_responder_if
//   Bus bundle between a CPU-side requester, the data cache and the backing
//   line memory.
//   CPU side : mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
//              (requester -> cache); mem_rdata, mem_resp (cache -> requester)
//   Line side: pmem_address, pmem_read, pmem_write, pmem_wdata
//              (cache -> memory); pmem_rdata, pmem_resp (memory -> cache)
//   Modports : slave  = the cache's view
//              master = the environment's view (CPU plus backing memory)
interface d_cache_responder_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;

  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/d_cache_responder.sv
// d_cache_responder
//   Direct-mapped write-back / write-allocate data cache: 8 sets of 32-byte
//   lines. Address split: word [4:2], index [7:5], tag [31:8].
//   Ports:
//     clk   - sole clock, rising edge
//     rst_n - synchronous active-low reset; clears valid/dirty, returns to IDLE
//     bus   - d_cache_responder_if.slave (CPU request side + line memory side)
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | serve hits in the request cycle; on a miss pick next state
//   S_WRITEBACK| push the dirty victim line out until pmem_resp
//   S_FILL     | fetch the requested line until pmem_resp, then back to IDLE
//
//   The state, tag, data, valid and dirty arrays are all held in the single
//   FSM always_ff. The bus outputs are decoded from that registered state:
//   a hit must answer in the same cycle, and a reset must pull the line
//   strobes low in the very cycle rst_n drops, so neither can wait a clock.
module d_cache_responder (
  input  logic                 clk,
  input  logic                 rst_n,
  d_cache_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_t;

  state_t         r_state;
  logic [7:0]     r_valid;
  logic [7:0]     r_dirty;
  logic [23:0]    r_tag  [8];
  logic [255:0]   r_data [8];

  logic [2:0]     w_index;
  logic [2:0]     w_word;
  logic [23:0]    w_tag;
  logic           w_req;
  logic           w_hit;
  logic [31:0]    w_old_word;
  logic [31:0]    w_new_word;
  logic           w_unused;

  assign w_word  = bus.mem_address[4:2];
  assign w_index = bus.mem_address[7:5];
  assign w_tag   = bus.mem_address[31:8];
  // Byte offset within the word is irrelevant; lanes come from the byte mask.
  assign w_unused = ^bus.mem_address[1:0];

  assign w_req = bus.mem_read | bus.mem_write;
  assign w_hit = (r_state == S_IDLE) && w_req && r_valid[w_index] &&
                 (r_tag[w_index] == w_tag);

  assign w_old_word = r_data[w_index][{w_word, 5'b00000} +: 32];

  always_comb begin
    w_new_word = w_old_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_enable[b]) begin
        w_new_word[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end
  end

  // Tag and data arrays are deliberately left out of the reset branch; the
  // cleared valid bits make their contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              // Read+write together is a write; an empty mask still dirties.
              if (bus.mem_write) begin
                r_data[w_index][{w_word, 5'b00000} +: 32] <= w_new_word;
                r_dirty[w_index] <= 1'b1;
              end
            end else if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state <= S_WRITEBACK;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.pmem_resp) begin
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.pmem_resp) begin
            r_data[w_index]  <= bus.pmem_rdata;
            r_tag[w_index]   <= w_tag;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write hits respond without read data so mem_rdata carries only reads.
  assign bus.mem_resp  = rst_n & w_hit;
  assign bus.mem_rdata = (rst_n && w_hit && !bus.mem_write) ? w_old_word : 32'h0;

  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 32'h0;
    bus.pmem_wdata   = '0;
    if (rst_n) begin
      case (r_state)
        S_WRITEBACK: begin
          bus.pmem_write   = 1'b1;
          bus.pmem_address = {r_tag[w_index], w_index, 5'b00000};
          bus.pmem_wdata   = r_data[w_index];
        end
        S_FILL: begin
          bus.pmem_read    = 1'b1;
          bus.pmem_address = {w_tag, w_index, 5'b00000};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_responder.sv
// tb_d_cache_responder
//   Directed bench for d_cache_responder: cold miss, write hits, dirty and
//   clean evictions, reset during a fill, read+write collision and a
//   write-allocate miss. Inputs change on the falling edge; outputs are
//   checked 1 ns later.
module tb_d_cache_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  d_cache_responder_if bus ();

  d_cache_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks    = 0;
  int n_errors    = 0;
  int n_overlap   = 0;
  int n_wb_cycles = 0;
  int wb_before   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = a;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] w1);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      l[32*w +: 32] = (w == 1) ? w1 : base + 32'(w);
    end
    return l;
  endfunction

  always @(negedge clk) begin
    #2;
    if (bus.pmem_read && bus.pmem_write) n_overlap++;
    if (bus.pmem_write) n_wb_cycles++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu(0, 0, 32'h0, 4'h0, 32'h0);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp",   bus.mem_resp,     1'b0);
    chk("rst_rdata",  bus.mem_rdata,    32'h0);
    chk("rst_pread",  bus.pmem_read,    1'b0);
    chk("rst_pwrite", bus.pmem_write,   1'b0);
    chk("rst_paddr",  bus.pmem_address, 32'h0);
    chk("rst_pwdata", bus.pmem_wdata,   256'h0);
    @(negedge clk); rst_n = 1'b1;

    // cold read miss
    @(negedge clk); cpu(1, 0, 32'h104, 4'h0, 32'h0); #1;
    chk("cold_miss_resp", bus.mem_resp, 1'b0);
    chk("cold_idle_pread", bus.pmem_read, 1'b0);
    @(negedge clk); #1;
    chk("cold_fill_pread", bus.pmem_read, 1'b1);
    chk("cold_fill_pwrite", bus.pmem_write, 1'b0);
    chk("cold_fill_paddr", bus.pmem_address, 32'h100);
    @(negedge clk); bus.pmem_rdata = mk_line(32'h1000_0000, 32'hDEADBEEF); bus.pmem_resp = 1'b1; #1;
    chk("cold_fill_hold", bus.pmem_read, 1'b1);
    chk("cold_fill_noresp", bus.mem_resp, 1'b0);
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("cold_hit_resp", bus.mem_resp, 1'b1);
    chk("cold_hit_rdata", bus.mem_rdata, 32'hDEADBEEF);
    chk("cold_idle_pread2", bus.pmem_read, 1'b0);

    // write hits
    @(negedge clk); cpu(0, 1, 32'h104, 4'b0010, 32'h0000AA00); #1;
    chk("wr_hit_resp", bus.mem_resp, 1'b1);
    chk("wr_hit_rdata", bus.mem_rdata, 32'h0);
    @(negedge clk); cpu(1, 0, 32'h104, 4'h0, 32'h0); #1;
    chk("rd_after_wr", bus.mem_rdata, 32'hDEADAAEF);
    @(negedge clk); cpu(1, 0, 32'h100, 4'h0, 32'h0); #1;
    chk("rd_word0", bus.mem_rdata, 32'h1000_0000);
    @(negedge clk); cpu(1, 0, 32'h107, 4'h0, 32'h0); #1;
    chk("rd_low_bits_ignored", bus.mem_rdata, 32'hDEADAAEF);
    @(negedge clk); cpu(0, 1, 32'h108, 4'h0, 32'hFFFF_FFFF); #1;
    chk("wr_be0_resp", bus.mem_resp, 1'b1);
    @(negedge clk); cpu(1, 0, 32'h108, 4'h0, 32'h0); #1;
    chk("wr_be0_unchanged", bus.mem_rdata, 32'h1000_0002);
    @(negedge clk); cpu(0, 0, 32'h0, 4'h0, 32'h0); #1;
    chk("noreq_resp", bus.mem_resp, 1'b0);
    chk("noreq_rdata", bus.mem_rdata, 32'h0);

    // dirty eviction
    @(negedge clk); cpu(1, 0, 32'h1104, 4'h0, 32'h0); #1;
    chk("dirty_miss_resp", bus.mem_resp, 1'b0);
    @(negedge clk); #1;
    chk("wb_pwrite", bus.pmem_write, 1'b1);
    chk("wb_pread", bus.pmem_read, 1'b0);
    chk("wb_paddr", bus.pmem_address, 32'h100);
    chk("wb_pwdata", bus.pmem_wdata, mk_line(32'h1000_0000, 32'hDEADAAEF));
    chk("wb_noresp", bus.mem_resp, 1'b0);
    @(negedge clk); bus.pmem_resp = 1'b1; #1;
    chk("wb_hold", bus.pmem_write, 1'b1);
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("evict_fill_pread", bus.pmem_read, 1'b1);
    chk("evict_fill_pwrite", bus.pmem_write, 1'b0);
    chk("evict_fill_paddr", bus.pmem_address, 32'h1100);
    @(negedge clk); bus.pmem_rdata = mk_line(32'h2000_0000, 32'hCAFEF00D); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("evict_hit_resp", bus.mem_resp, 1'b1);
    chk("evict_hit_rdata", bus.mem_rdata, 32'hCAFEF00D);

    // clean eviction
    wb_before = n_wb_cycles;
    @(negedge clk); cpu(1, 0, 32'h2104, 4'h0, 32'h0); #1;
    chk("clean_miss_resp", bus.mem_resp, 1'b0);
    @(negedge clk); #1;
    chk("clean_fill_pread", bus.pmem_read, 1'b1);
    chk("clean_fill_pwrite", bus.pmem_write, 1'b0);
    chk("clean_fill_paddr", bus.pmem_address, 32'h2100);
    @(negedge clk); bus.pmem_rdata = mk_line(32'h3000_0000, 32'h12345678); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("clean_hit_rdata", bus.mem_rdata, 32'h12345678);
    chk("clean_no_wb", n_wb_cycles - wb_before, 0);

    // empty-mask write still dirties the line
    @(negedge clk); cpu(0, 1, 32'h2104, 4'h0, 32'hFFFF_FFFF); #1;
    chk("be0_clean_resp", bus.mem_resp, 1'b1);
    @(negedge clk); cpu(1, 0, 32'h2104, 4'h0, 32'h0); #1;
    chk("be0_clean_data", bus.mem_rdata, 32'h12345678);
    @(negedge clk); cpu(1, 0, 32'h3104, 4'h0, 32'h0); #1;
    chk("be0_miss_resp", bus.mem_resp, 1'b0);
    @(negedge clk); #1;
    chk("be0_wb_pwrite", bus.pmem_write, 1'b1);
    chk("be0_wb_paddr", bus.pmem_address, 32'h2100);
    chk("be0_wb_pwdata", bus.pmem_wdata, mk_line(32'h3000_0000, 32'h12345678));
    @(negedge clk); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("be0_fill_pread", bus.pmem_read, 1'b1);
    chk("be0_fill_paddr", bus.pmem_address, 32'h3100);
    @(negedge clk); bus.pmem_rdata = mk_line(32'h4000_0000, 32'h0BADCAFE); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("be0_hit_rdata", bus.mem_rdata, 32'h0BADCAFE);

    // read+write together behaves as a write
    @(negedge clk); cpu(1, 1, 32'h3104, 4'hF, 32'hA5A5A5A5); #1;
    chk("rw_resp", bus.mem_resp, 1'b1);
    chk("rw_rdata", bus.mem_rdata, 32'h0);
    @(negedge clk); cpu(1, 0, 32'h3104, 4'h0, 32'h0); #1;
    chk("rw_readback", bus.mem_rdata, 32'hA5A5A5A5);
    @(negedge clk); cpu(1, 0, 32'h4104, 4'h0, 32'h0); #1;
    chk("rw_miss_resp", bus.mem_resp, 1'b0);
    @(negedge clk); #1;
    chk("rw_wb_pwrite", bus.pmem_write, 1'b1);
    chk("rw_wb_paddr", bus.pmem_address, 32'h3100);
    chk("rw_wb_pwdata", bus.pmem_wdata, mk_line(32'h4000_0000, 32'hA5A5A5A5));
    @(negedge clk); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("rw_fill_pread", bus.pmem_read, 1'b1);
    chk("rw_fill_paddr", bus.pmem_address, 32'h4100);

    // reset during FILL abandons the fetch
    @(negedge clk); rst_n = 1'b0;
    bus.pmem_rdata = mk_line(32'h7000_0000, 32'h77777777); bus.pmem_resp = 1'b1; #1;
    chk("rstfill_pread", bus.pmem_read, 1'b0);
    chk("rstfill_pwrite", bus.pmem_write, 1'b0);
    chk("rstfill_paddr", bus.pmem_address, 32'h0);
    chk("rstfill_resp", bus.mem_resp, 1'b0);
    @(negedge clk); bus.pmem_resp = 1'b0; cpu(0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); cpu(1, 0, 32'h4104, 4'h0, 32'h0); #1;
    chk("post_rst_miss", bus.mem_resp, 1'b0);
    @(negedge clk); #1;
    chk("post_rst_pread", bus.pmem_read, 1'b1);
    chk("post_rst_pwrite", bus.pmem_write, 1'b0);
    chk("post_rst_paddr", bus.pmem_address, 32'h4100);
    @(negedge clk); bus.pmem_rdata = mk_line(32'h5000_0000, 32'h600DF00D); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("post_rst_hit", bus.mem_resp, 1'b1);
    chk("post_rst_rdata", bus.mem_rdata, 32'h600DF00D);

    // stray pmem_resp in IDLE has no effect
    @(negedge clk); cpu(0, 0, 32'h0, 4'h0, 32'h0); bus.pmem_rdata = '0; bus.pmem_resp = 1'b1; #1;
    chk("stray_pread", bus.pmem_read, 1'b0);
    @(negedge clk); bus.pmem_resp = 1'b0; cpu(1, 0, 32'h4104, 4'h0, 32'h0); #1;
    chk("stray_hit", bus.mem_resp, 1'b1);
    chk("stray_rdata", bus.mem_rdata, 32'h600DF00D);

    // write miss allocates, then completes as a write hit
    @(negedge clk); cpu(0, 1, 32'h20, 4'b1001, 32'h11223344); #1;
    chk("wa_miss_resp", bus.mem_resp, 1'b0);
    @(negedge clk); #1;
    chk("wa_fill_pread", bus.pmem_read, 1'b1);
    chk("wa_fill_paddr", bus.pmem_address, 32'h20);
    @(negedge clk); bus.pmem_rdata = '1; bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; #1;
    chk("wa_hit_resp", bus.mem_resp, 1'b1);
    @(negedge clk); cpu(1, 0, 32'h20, 4'h0, 32'h0); #1;
    chk("wa_merge", bus.mem_rdata, 32'h11FFFF44);
    @(negedge clk); cpu(1, 0, 32'h24, 4'h0, 32'h0); #1;
    chk("wa_other_word", bus.mem_rdata, 32'hFFFF_FFFF);
    @(negedge clk); cpu(0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk); #3;
    chk("no_rd_wr_overlap", n_overlap, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/d_cache_responder.md
D_CACHE_RESPONDER -- requirements
Module: d_cache_responder

Interface
REQ-001 SHALL have these parameters: none; geometry is fixed at direct-mapped, 8 sets, 32-byte lines, write-back, write-allocate.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_address  in  32  CPU byte address; bits [1:0] ignored.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_byte_enable  in  4  write byte mask, bit i for byte lane i.
- mem_wdata  in  32  write data, lane-aligned.
- mem_rdata  out  32  read data, valid only with mem_resp.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line address, bits [4:0] always zero.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_wdata  out  256  victim line data.
- pmem_rdata  in  256  fill line data.
- pmem_resp  in  1  backing-memory completion.

Function
REQ-003 SHALL decode the address as: offset [4:0], word select [4:2], index [7:5], tag [31:8] (24 bits).
REQ-004 SHALL keep per set: valid bit, dirty bit, 24-bit tag and 256-bit data; word w occupies data bits [32w+31:32w].
REQ-005 SHALL implement an FSM with states IDLE, WRITEBACK and FILL.
REQ-006 A hit is: in IDLE, request active, valid[index] set and tag[index] equal to the address tag.
REQ-007 On a read hit, SHALL assert mem_resp combinationally in the same cycle and drive mem_rdata with the selected word.
REQ-008 On a write hit, SHALL assert mem_resp in the same cycle; on that clock edge SHALL update only the enabled byte lanes and set dirty[index].
REQ-009 A write hit with mem_byte_enable=0 SHALL leave data unchanged, still respond, and still set dirty.
REQ-010 mem_read and mem_write both high SHALL be treated as a write.
REQ-011 On a miss in IDLE:
- victim valid and dirty: next state WRITEBACK.
- otherwise: next state FILL.
- mem_resp stays 0.
REQ-012 In WRITEBACK:
- drive pmem_write=1, pmem_address={stored tag, index, 5'b0}, pmem_wdata=line data.
- hold these until the cycle pmem_resp=1, then go to FILL.
REQ-013 In FILL:
- drive pmem_read=1, pmem_address={request tag, index, 5'b0}.
- on the pmem_resp=1 edge, load pmem_rdata, write the tag, set valid, clear dirty, and go to IDLE.
REQ-014 After FILL, the request SHALL complete as a hit in the following IDLE cycle.
- Miss latency = WRITEBACK cycles + FILL cycles + 1.
REQ-015 pmem_read and pmem_write SHALL never be high together, and neither SHALL be high in IDLE.
REQ-016 pmem_resp in IDLE SHALL be ignored.
REQ-017 mem_rdata SHALL be 0 whenever mem_resp is 0.
REQ-018 mem_resp SHALL be 0 in WRITEBACK and FILL.
REQ-019 The request inputs are held stable by the requester until mem_resp; the block does not latch them.
REQ-020 With no request in IDLE, no state SHALL change.

Reset
REQ-021 When rst_n=0 at a clock edge, SHALL go to IDLE and clear all valid and dirty bits.
- Tag and data arrays are not reset.
REQ-022 While rst_n=0, outputs SHALL be: mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
REQ-023 Reset asserted during WRITEBACK or FILL SHALL abandon the transaction: no array update, and pmem_read/pmem_write low from the reset cycle onward.
REQ-024 After rst_n returns to 1, the first request SHALL miss.

Verification
REQ-025 Cold read: after reset, read 0x00000104 -> FILL with pmem_address=0x00000100; fill supplies word1=0xDEADBEEF; mem_resp one cycle after pmem_resp with mem_rdata=0xDEADBEEF.
REQ-026 Write hit: write 0x00000104, byte_enable=4'b0010, wdata=0x0000AA00 -> same-cycle mem_resp; a later read returns 0xDEADAAEF.
REQ-027 Dirty eviction: after REQ-026, read 0x00001104 (same index, new tag):
- WRITEBACK with pmem_address=0x00000100 and pmem_wdata word1=0xDEADAAEF.
- then FILL with pmem_address=0x00001100.
- pmem_read and pmem_write never overlap.
REQ-028 Clean eviction: read a conflicting tag to a clean line -> goes directly to FILL; pmem_write never asserted.
REQ-029 Reset mid-FILL: rst_n=0 while pmem_read=1 -> pmem_read=0 the same cycle; after reset, rereading the address misses.
REQ-030 Read+write simultaneous: mem_read=mem_write=1 with byte_enable=4'hF on a hit -> data written and dirty set; mem_rdata=0.
